// File: rtl/wb_gpio_irq_pkg.sv
// Shared definitions for the wb_gpio_irq Wishbone GPIO peripheral:
// register word addresses and the bus handshake state type.
package wb_gpio_irq_pkg;

    localparam logic [2:0] ADDR_GPIO       = 3'd0;
    localparam logic [2:0] ADDR_OUT_MASK   = 3'd1;
    localparam logic [2:0] ADDR_INT_EN     = 3'd2;
    localparam logic [2:0] ADDR_INT_EDGE   = 3'd3;
    localparam logic [2:0] ADDR_INT_STATUS = 3'd4;

    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_ACK  = 1'b1
    } bus_state_t;

endpackage

// File: rtl/gpio_in_filter.sv
// Input conditioning for wb_gpio_irq: a SYNC_STAGES-deep synchroniser per bit,
// optionally followed by a per-bit debounce counter when GPIO_DEBOUNCE_EN is
// defined. Without the macro, in_f is the synchroniser output.
module gpio_in_filter #(
    parameter int GPIO_WIDTH    = 32,
    parameter int SYNC_STAGES   = 2,
    parameter int DEBOUNCE_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [GPIO_WIDTH-1:0] gpio_in,
    output logic [GPIO_WIDTH-1:0] in_f
);

    logic [GPIO_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [GPIO_WIDTH-1:0] sync_out;

    // Shift the asynchronous inputs through the synchroniser chain
    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the previous stage's pre-edge value, forming a real shift chain.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
    logic [DEBOUNCE_LOG2-1:0] cnt_q [GPIO_WIDTH];

    // Accept a new level only after 2^DEBOUNCE_LOG2 consecutive mismatching cycles
    always_ff @(posedge clk) begin
        if (!rst) begin
            in_f <= '0;
            for (int n = 0; n < GPIO_WIDTH; n++) cnt_q[n] <= '0;
        end else begin
            for (int n = 0; n < GPIO_WIDTH; n++) begin
                if (sync_out[n] == in_f[n]) begin
                    cnt_q[n] <= '0;
                end else if (&cnt_q[n]) begin
                    in_f[n]  <= sync_out[n];
                    cnt_q[n] <= '0;
                end else begin
                    cnt_q[n] <= cnt_q[n] + 1'b1;
                end
            end
        end
    end
`else
    // Without debounce the filter is a pure synchroniser; DEBOUNCE_LOG2 only
    // sizes the counters of the debounced build.
    if (DEBOUNCE_LOG2 >= 0) begin : g_no_debounce
        assign in_f = sync_out;
    end
`endif

endmodule

// File: rtl/wb_gpio_irq.sv
// wb_gpio_irq: Wishbone slave GPIO with masked output writes, synchronised
// (optionally debounced, macro GPIO_DEBOUNCE_EN) inputs and per-bit
// edge-triggered interrupts with write-1-to-clear status.
// Register bits at and above GPIO_WIDTH read 0 and ignore writes.
module wb_gpio_irq
    import wb_gpio_irq_pkg::*;
#(
    parameter int GPIO_WIDTH    = 32,
    parameter int SYNC_STAGES   = 2,
    parameter int DEBOUNCE_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wbs_we_i,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_stb_i,
    input  logic [31:0]           wbs_adr_i,
    input  logic [31:0]           wbs_dat_i,
    output logic [31:0]           wbs_dat_o,
    output logic                  wbs_ack_o,
    output logic                  wbs_int_o,
    input  logic [GPIO_WIDTH-1:0] gpio_in,
    output logic [GPIO_WIDTH-1:0] gpio_out
);

    bus_state_t            state;
    logic [GPIO_WIDTH-1:0] in_f;
    logic [GPIO_WIDTH-1:0] in_prev;
    logic [GPIO_WIDTH-1:0] out_mask;
    logic [GPIO_WIDTH-1:0] int_en;
    logic [GPIO_WIDTH-1:0] int_edge;
    logic [GPIO_WIDTH-1:0] int_status;

    logic                  access;
    logic                  mapped;
    logic                  wr;
    logic [2:0]            reg_sel;
    logic [GPIO_WIDTH-1:0] wdat;
    logic [GPIO_WIDTH-1:0] rise;
    logic [GPIO_WIDTH-1:0] fall;
    logic [GPIO_WIDTH-1:0] edge_set;
    logic [GPIO_WIDTH-1:0] w1c;
    logic [31:0]           rdata;

    gpio_in_filter #(
        .GPIO_WIDTH   (GPIO_WIDTH),
        .SYNC_STAGES  (SYNC_STAGES),
        .DEBOUNCE_LOG2(DEBOUNCE_LOG2)
    ) u_in_filter (
        .clk    (clk),
        .rst    (rst),
        .gpio_in(gpio_in),
        .in_f   (in_f)
    );

    // A new access is only recognised from IDLE, so a held strobe is acked
    // once every two cycles.
    assign access  = (state == BUS_IDLE) && wbs_cyc_i && wbs_stb_i;
    assign mapped  = (wbs_adr_i[31:3] == '0);
    assign reg_sel = wbs_adr_i[2:0];
    assign wr      = access && wbs_we_i && mapped;
    assign wdat    = wbs_dat_i[GPIO_WIDTH-1:0];

    // Edge detection on the filtered input; INT_EDGE bit 1 selects rising.
    assign rise     = in_f & ~in_prev;
    assign fall     = ~in_f & in_prev;
    assign edge_set = (rise & int_edge) | (fall & ~int_edge);
    assign w1c      = (wr && (reg_sel == ADDR_INT_STATUS)) ? wdat : '0;

    // Read data mux, zero-extended to the bus width; unmapped reads return 0
    // NOTE: rdata gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        rdata = '0;
        if (mapped) begin
            case (reg_sel)
                ADDR_GPIO:       rdata[GPIO_WIDTH-1:0] = in_f;
                ADDR_OUT_MASK:   rdata[GPIO_WIDTH-1:0] = out_mask;
                ADDR_INT_EN:     rdata[GPIO_WIDTH-1:0] = int_en;
                ADDR_INT_EDGE:   rdata[GPIO_WIDTH-1:0] = int_edge;
                ADDR_INT_STATUS: rdata[GPIO_WIDTH-1:0] = int_status;
                default:         rdata = '0;
            endcase
        end
    end

    // Bus handshake FSM: IDLE -> ACK -> IDLE with registered ack and read data
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= BUS_IDLE;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            case (state)
                BUS_IDLE: begin
                    if (access) begin
                        state     <= BUS_ACK;
                        wbs_ack_o <= 1'b1;
                        wbs_dat_o <= rdata;
                    end
                end
                BUS_ACK: begin
                    state     <= BUS_IDLE;
                    wbs_ack_o <= 1'b0;
                end
                default: begin
                    state     <= BUS_IDLE;
                    wbs_ack_o <= 1'b0;
                end
            endcase
        end
    end

    // Register writes, interrupt status and the registered interrupt line
    always_ff @(posedge clk) begin
        if (!rst) begin
            gpio_out   <= '0;
            out_mask   <= '1;
            int_en     <= '0;
            int_edge   <= '1;
            int_status <= '0;
            in_prev    <= '0;
            wbs_int_o  <= 1'b0;
        end else begin
            in_prev    <= in_f;
            // Set is OR-ed in after the clear so a new edge wins over W1C.
            int_status <= (int_status & ~w1c) | edge_set;
            wbs_int_o  <= |(int_status & int_en);
            if (wr) begin
                case (reg_sel)
                    ADDR_GPIO:     gpio_out <= (gpio_out & ~out_mask) | (wdat & out_mask);
                    ADDR_OUT_MASK: out_mask <= wdat;
                    ADDR_INT_EN:   int_en   <= wdat;
                    ADDR_INT_EDGE: int_edge <= wdat;
                    default:       ;
                endcase
            end
        end
    end

endmodule
